// File: rtl/shifter8_arbiter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shifter8_arbiter_seq
//  Purpose  : Round-robin arbiter that shares one external shifter8 datapath
//             (cc_logic + 8-bit register) between two requesters. A granted
//             job loads its byte into the shifter and then issues shift
//             chunks of at most MAX_CHUNK bits per cycle until the requested
//             amount is used up. The shifted byte is returned with a one-cycle
//             done pulse that is tagged with the owning requester.
//  Ports    : clk, reset_n             clock, asynchronous active-low reset
//             req0/1, op0/1,           request handshake and job fields
//             amt0/1, din0/1
//             ack0/1                   one-cycle accept pulse (IDLE only)
//             sh_op, sh_shamt, sh_d_in command bus to the shifter
//             sh_d_out                 shifter register contents
//             busy, done, done_id,     status and result
//             result
//  Revision : 1.0  initial release
// ============================================================================
module shifter8_arbiter_seq #(
    parameter int MAX_CHUNK = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [3:0] amt0,
    input  logic [3:0] amt1,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] sh_op,
    output logic [1:0] sh_shamt,
    output logic [7:0] sh_d_in,
    input  logic [7:0] sh_d_out,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] result
);

    localparam logic [1:0] c_MAX_CHUNK = 2'(MAX_CHUNK);

    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_LSL  = 3'b010;
    localparam logic [2:0] c_OP_LSR  = 3'b011;
    localparam logic [2:0] c_OP_ASR  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_op;
    logic [3:0] r_rem;
    logic [7:0] r_din;
    logic       r_owner;
    logic       r_last_grant;
    logic [7:0] r_result;

    logic       w_grant0;
    logic       w_grant1;
    logic [2:0] w_req_op;
    logic [3:0] w_req_amt;
    logic [7:0] w_req_din;
    logic       w_op_legal;
    logic [1:0] w_chunk;
    logic [3:0] w_rem_next;

    // Grants exist only in IDLE. The reset term keeps the ack outputs low
    // while reset is held, even if a requester is already waiting.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset_n && (r_state == S_IDLE)) begin
            if (req0 && req1) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = req0;
                w_grant1 = req1;
            end
        end
    end

    assign w_req_op   = w_grant1 ? op1  : op0;
    assign w_req_amt  = w_grant1 ? amt1 : amt0;
    assign w_req_din  = w_grant1 ? din1 : din0;
    assign w_op_legal = (w_req_op == c_OP_LSL) || (w_req_op == c_OP_LSR) ||
                        (w_req_op == c_OP_ASR);

    // Chunk never exceeds rem, so rem cannot underflow.
    assign w_chunk    = (r_rem > {2'b00, c_MAX_CHUNK}) ? c_MAX_CHUNK : r_rem[1:0];
    assign w_rem_next = r_rem - {2'b00, w_chunk};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_op         <= c_OP_NOP;
            r_rem        <= 4'd0;
            r_din        <= 8'd0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_result     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_op         <= w_req_op;
                        // Illegal ops skip the shift phase and return din.
                        r_rem        <= w_op_legal ? w_req_amt : 4'd0;
                        r_din        <= w_req_din;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= (r_rem != 4'd0) ? S_SHIFT : S_DONE;
                end
                S_SHIFT: begin
                    r_rem <= w_rem_next;
                    if (w_rem_next == 4'd0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_result <= sh_d_out;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Shifter command bus is a pure decode of registered state.
    always_comb begin
        sh_op    = c_OP_NOP;
        sh_shamt = 2'd0;
        sh_d_in  = 8'd0;
        case (r_state)
            S_LOAD: begin
                sh_op   = c_OP_LOAD;
                sh_d_in = r_din;
            end
            S_SHIFT: begin
                sh_op    = r_op;
                sh_shamt = w_chunk;
            end
            default: begin
                sh_op = c_OP_NOP;
            end
        endcase
    end

    assign ack0    = w_grant0;
    assign ack1    = w_grant1;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign done_id = r_owner;
    // During DONE the shifter already holds the final byte; afterwards the
    // captured copy keeps the result stable until the next job finishes.
    assign result  = done ? sh_d_out : r_result;

endmodule
`default_nettype wire

// File: tb/tb_shifter8_arbiter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shifter8_arbiter_seq
//  Purpose  : Self-checking bench for shifter8_arbiter_seq with a behavioural
//             shifter8 register attached to the command bus. Expected jobs
//             are queued on ack and retired on done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shifter8_arbiter_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [3:0] amt0, amt1;
    logic [7:0] din0, din1;
    logic       ack0, ack1;
    logic [2:0] sh_op;
    logic [1:0] sh_shamt;
    logic [7:0] sh_d_in;
    logic [7:0] sh_d_out;
    logic       busy, done, done_id;
    logic [7:0] result;

    always #5 clk = ~clk;

    shifter8_arbiter_seq #(.MAX_CHUNK(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .op0      (op0),
        .op1      (op1),
        .amt0     (amt0),
        .amt1     (amt1),
        .din0     (din0),
        .din1     (din1),
        .ack0     (ack0),
        .ack1     (ack1),
        .sh_op    (sh_op),
        .sh_shamt (sh_shamt),
        .sh_d_in  (sh_d_in),
        .sh_d_out (sh_d_out),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .result   (result)
    );

    // Behavioural shifter8 register
    logic [7:0] shreg = 8'd0;
    always @(posedge clk) begin
        case (sh_op)
            3'b001:  shreg <= sh_d_in;
            3'b010:  shreg <= shreg << sh_shamt;
            3'b011:  shreg <= shreg >> sh_shamt;
            3'b100:  shreg <= 8'($signed(shreg) >>> sh_shamt);
            default: shreg <= shreg;
        endcase
    end
    assign sh_d_out = shreg;

    typedef struct {
        logic       id;
        logic [7:0] res;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] trace[$];
    int         grants[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         ack_cyc[2];
    int         done_cyc[2];
    logic [7:0] last_res = 8'd0;

    logic [4:0] tr2 [3] = '{5'b00100, 5'b01011, 5'b01010};
    logic [4:0] tr3 [4] = '{5'b00100, 5'b10011, 5'b10011, 5'b10001};
    logic [4:0] tr6 [6] = '{5'b00100, 5'b01111, 5'b01111, 5'b01111, 5'b01111, 5'b01111};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [3:0] amt,
                                              input logic [7:0] d);
        logic [7:0] r;
        case (op)
            3'b010:  r = d << amt;
            3'b011:  r = d >> amt;
            3'b100:  r = 8'($signed(d) >>> amt);
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [3:0] amt);
        if (op == 3'b010 || op == 3'b011 || op == 3'b100)
            return 2 + (int'(amt) + 2) / 3;
        return 2;
    endfunction

    // Monitor: push on ack, pop and compare on done, log shifter commands.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n) begin
            if (ack0 || ack1) begin
                check_eq("ack_one_hot", 32'(ack0 & ack1), 32'd0);
                check_eq("ack_while_busy", 32'(busy), 32'd0);
                e.id  = ack1;
                e.res = ack1 ? ref_result(op1, amt1, din1) : ref_result(op0, amt0, din0);
                e.due = cyc + (ack1 ? ref_latency(op1, amt1) : ref_latency(op0, amt0));
                sb.push_back(e);
                grants.push_back(ack1 ? 1 : 0);
                ack_cyc[ack1 ? 1 : 0] = cyc;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_id", 32'(done_id), 32'(e.id));
                    check_eq("result", 32'(result), 32'(e.res));
                    check_eq("done_cycle", cyc, e.due);
                    done_cyc[done_id ? 1 : 0] = cyc;
                    last_res = result;
                end
            end
            if (sh_op != 3'b000) trace.push_back({sh_op, sh_shamt});
        end
    end

    task automatic do_req(input int id, input logic [2:0] op, input logic [3:0] amt,
                          input logic [7:0] d);
        bit got = 1'b0;
        if (id == 0) begin
            op0 = op; amt0 = amt; din0 = d; req0 = 1'b1;
        end else begin
            op1 = op; amt1 = amt; din1 = d; req1 = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((id == 0) ? ack0 : ack1) begin
                got = 1'b1;
                break;
            end
        end
        check_eq($sformatf("ack_seen_req%0d", id), 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("drain", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},    32'(busy),     32'd0);
        check_eq({tag, "_sh_op"},   32'(sh_op),    32'd0);
        check_eq({tag, "_shamt"},   32'(sh_shamt), 32'd0);
        check_eq({tag, "_d_in"},    32'(sh_d_in),  32'd0);
        check_eq({tag, "_done"},    32'(done),     32'd0);
        check_eq({tag, "_done_id"}, 32'(done_id),  32'd0);
        check_eq({tag, "_result"},  32'(result),   32'd0);
        check_eq({tag, "_ack0"},    32'(ack0),     32'd0);
        check_eq({tag, "_ack1"},    32'(ack1),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; amt0 = '0; amt1 = '0; din0 = '0; din1 = '0;
        repeat (2) @(negedge clk);
        req0 = 1'b1;                         // a waiting request must not be acked in reset
        #1;
        check_idle_outputs("rst");
        req0 = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // LSL by 5 of 0x5C
        trace.delete();
        do_req(0, 3'b010, 4'd5, 8'h5C);
        drain();
        check_eq("t2_result", 32'(last_res), 32'h80);
        check_eq("t2_trace_len", trace.size(), 3);
        for (int i = 0; i < 3 && i < trace.size(); i++)
            check_eq($sformatf("t2_trace%0d", i), 32'(trace[i]), 32'(tr2[i]));

        // ASR by 7 of 0xDC
        trace.delete();
        do_req(1, 3'b100, 4'd7, 8'hDC);
        drain();
        check_eq("t3_result", 32'(last_res), 32'hFF);
        check_eq("t3_trace_len", trace.size(), 4);
        for (int i = 0; i < 4 && i < trace.size(); i++)
            check_eq($sformatf("t3_trace%0d", i), 32'(trace[i]), 32'(tr3[i]));

        // Reset in the middle of a long job
        do_req(0, 3'b011, 4'd15, 8'hF0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);          // any done here is reported as spurious
        @(posedge clk);
        #1;

        // Both held: first grant after reset goes to requester 0, then alternate
        grants.delete();
        fork
            begin
                do_req(0, 3'b011, 4'd2, 8'hCD);
                do_req(0, 3'b011, 4'd2, 8'hCD);
            end
            begin
                do_req(1, 3'b011, 4'd2, 8'h4D);
                do_req(1, 3'b011, 4'd2, 8'h4D);
            end
        join
        drain();
        check_eq("t4_grant_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_eq($sformatf("t4_grant%0d", i), grants[i], i % 2);

        // Zero shift and illegal op both return din after LOAD then DONE
        do_req(0, 3'b010, 4'd0, 8'hA5);
        drain();
        check_eq("t5_result", 32'(last_res), 32'hA5);
        check_eq("t5_result_hold", 32'(result), 32'hA5);
        do_req(1, 3'b111, 4'd5, 8'h3C);
        drain();
        check_eq("t5_illegal_result", 32'(last_res), 32'h3C);

        // Longest job; competing request raised mid-job waits for the next IDLE
        trace.delete();
        fork
            do_req(1, 3'b011, 4'd15, 8'hFF);
            begin
                repeat (3) @(posedge clk);
                #1;
                do_req(0, 3'b010, 4'd1, 8'h81);
            end
        join
        drain();
        check_eq("t6_ack0_gap", ack_cyc[0] - done_cyc[1], 1);
        check_eq("t6_last_result", 32'(last_res), 32'h02);
        check_eq("t6_trace_len_min", 32'(trace.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < trace.size(); i++)
            check_eq($sformatf("t6_trace%0d", i), 32'(trace[i]), 32'(tr6[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
